// File: rtl/eq2_seq_lock.sv
// eq2_seq_lock
//   Sequential code-lock stage. A strobed stream of 2-bit symbols is compared,
//   one symbol per strobe, against an N_SYM-symbol programmed key using
//   sum-of-products 2-bit equality. The block tracks key progress and
//   consecutive failed attempts, and enforces a timed lockout.
//
// Parameters
//   N_SYM       key length in symbols (2..8)
//   MAX_FAIL    consecutive failures that trigger lockout (1..3)
//   LOCKOUT_CYC lockout duration in clk cycles (1..255)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   sym_valid   one-cycle strobe qualifying sym
//   sym         entered symbol
//   key         programmed key, symbol i = key[2i+1:2i], symbol 0 entered first
//   clear       abort attempt / relock (ignored during lockout)
//   unlocked    high while OPEN
//   locked_out  high while LOCKOUT
//   fail_pulse  one-cycle pulse per failed attempt
//   pos         index of the next expected symbol
//   fail_cnt    consecutive failed attempts
module eq2_seq_lock #(
    parameter int unsigned N_SYM       = 4,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_valid,
    input  logic [1:0]         sym,
    input  logic [2*N_SYM-1:0] key,
    input  logic               clear,
    output logic               unlocked,
    output logic               locked_out,
    output logic               fail_pulse,
    output logic [2:0]         pos,
    output logic [1:0]         fail_cnt
);

    localparam logic [2:0] LAST_POS  = 3'(N_SYM - 1);
    localparam logic [1:0] FAIL_LIM  = 2'(MAX_FAIL);
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [2:0] pos_nx;
    logic [1:0] fail_cnt_nx;
    logic [1:0] fail_inc;
    logic [7:0] timer, timer_nx;
    logic       fail_pulse_nx;
    logic [1:0] key_sym;
    logic       match;

    // Expected symbol for the current position; pos never exceeds N_SYM-1.
    always_comb begin
        key_sym = '0;
        for (int unsigned i = 0; i < N_SYM; i++) begin
            if (pos == 3'(i)) begin
                key_sym = key[2*i +: 2];
            end
        end
    end

    // 2-bit equality as a sum of the four minterms where both operands agree.
    assign match = (~sym[1] & ~sym[0] & ~key_sym[1] & ~key_sym[0]) |
                   (~sym[1] &  sym[0] & ~key_sym[1] &  key_sym[0]) |
                   ( sym[1] & ~sym[0] &  key_sym[1] & ~key_sym[0]) |
                   ( sym[1] &  sym[0] &  key_sym[1] &  key_sym[0]);

    assign fail_inc = fail_cnt + 2'd1;

    always_comb begin
        state_nx      = state;
        pos_nx        = pos;
        fail_cnt_nx   = fail_cnt;
        timer_nx      = timer;
        fail_pulse_nx = 1'b0;

        unique case (state)
            IDLE, COLLECT: begin
                if (clear) begin
                    state_nx    = IDLE;
                    pos_nx      = '0;
                    fail_cnt_nx = '0;
                end else if (sym_valid) begin
                    if (match) begin
                        if (pos == LAST_POS) begin
                            state_nx    = OPEN;
                            pos_nx      = '0;
                            fail_cnt_nx = '0;
                        end else begin
                            state_nx = COLLECT;
                            pos_nx   = pos + 3'd1;
                        end
                    end else begin
                        // A mismatching symbol is not retried as symbol 0.
                        pos_nx        = '0;
                        fail_pulse_nx = 1'b1;
                        fail_cnt_nx   = fail_inc;
                        if (fail_inc == FAIL_LIM) begin
                            state_nx = LOCKOUT;
                            timer_nx = LOCK_LOAD;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            OPEN: begin
                if (clear) begin
                    state_nx    = IDLE;
                    pos_nx      = '0;
                    fail_cnt_nx = '0;
                end
            end
            LOCKOUT: begin
                // Loaded with LOCKOUT_CYC on entry, so exit on timer==1
                // gives exactly LOCKOUT_CYC cycles of locked_out.
                timer_nx = timer - 8'd1;
                if (timer == 8'd1) begin
                    state_nx    = IDLE;
                    fail_cnt_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            pos        <= '0;
            fail_cnt   <= '0;
            timer      <= '0;
            fail_pulse <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nx;
            pos        <= pos_nx;
            fail_cnt   <= fail_cnt_nx;
            timer      <= timer_nx;
            fail_pulse <= fail_pulse_nx;
            unlocked   <= (state_nx == OPEN);
            locked_out <= (state_nx == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_eq2_seq_lock.sv
// Testbench for eq2_seq_lock: table-driven per-cycle vectors followed by
// hand-written lockout and key-change sequences.
module tb_eq2_seq_lock;

    logic       clk = 1'b0;
    logic       reset;
    logic       sym_valid;
    logic [1:0] sym;
    logic [7:0] key;
    logic       clear;
    logic       unlocked;
    logic       locked_out;
    logic       fail_pulse;
    logic [2:0] pos;
    logic [1:0] fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    eq2_seq_lock #(
        .N_SYM(4),
        .MAX_FAIL(3),
        .LOCKOUT_CYC(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sym_valid(sym_valid),
        .sym(sym),
        .key(key),
        .clear(clear),
        .unlocked(unlocked),
        .locked_out(locked_out),
        .fail_pulse(fail_pulse),
        .pos(pos),
        .fail_cnt(fail_cnt)
    );

    typedef struct {
        logic       rst_n;
        logic       v;
        logic [1:0] s;
        logic       c;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Output bundle: {unlocked, locked_out, fail_pulse, pos[2:0], fail_cnt[1:0]}
    function automatic logic [7:0] mk(input logic u, input logic l, input logic p,
                                      input logic [2:0] ps, input logic [1:0] fc);
        return {u, l, p, ps, fc};
    endfunction

    function automatic vec_t vec(input logic r, input logic v, input logic [1:0] s,
                                 input logic c, input logic [7:0] e);
        vec_t t;
        t.rst_n = r;
        t.v     = v;
        t.s     = s;
        t.c     = c;
        t.exp   = e;
        return t;
    endfunction

    // Drive inputs, let one rising edge sample them, then settle before checking.
    task automatic cyc(input logic r, input logic v, input logic [1:0] s, input logic c);
        reset     = r;
        sym_valid = v;
        sym       = s;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {unlocked, locked_out, fail_pulse, pos, fail_cnt};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {u,l,p,pos,fc}=%b required %b", name, act, exp);
        end
    endtask

    logic [1:0] ks [4];

    initial begin
        reset     = 1'b0;
        sym_valid = 1'b0;
        sym       = 2'b00;
        clear     = 1'b0;
        key       = 8'h8D;
        ks[0] = 2'b01; ks[1] = 2'b11; ks[2] = 2'b00; ks[3] = 2'b10;

        // Key 8'h8D: symbols 01, 11, 00, 10.
        tbl.push_back(vec(0, 0, 2'b00, 0, mk(0,0,0,3'd0,2'd0))); // reset state
        tbl.push_back(vec(1, 1, 2'b01, 0, mk(0,0,0,3'd1,2'd0)));
        tbl.push_back(vec(1, 1, 2'b11, 0, mk(0,0,0,3'd2,2'd0)));
        tbl.push_back(vec(1, 1, 2'b00, 0, mk(0,0,0,3'd3,2'd0)));
        tbl.push_back(vec(1, 1, 2'b10, 0, mk(1,0,0,3'd0,2'd0))); // unlock
        tbl.push_back(vec(1, 0, 2'b00, 0, mk(1,0,0,3'd0,2'd0))); // stays open
        tbl.push_back(vec(1, 1, 2'b11, 0, mk(1,0,0,3'd0,2'd0))); // sym ignored in OPEN
        tbl.push_back(vec(1, 1, 2'b01, 1, mk(0,0,0,3'd0,2'd0))); // clear beats sym
        tbl.push_back(vec(1, 1, 2'b01, 0, mk(0,0,0,3'd1,2'd0)));
        tbl.push_back(vec(1, 1, 2'b10, 0, mk(0,0,1,3'd0,2'd1))); // mismatch
        tbl.push_back(vec(1, 0, 2'b00, 0, mk(0,0,0,3'd0,2'd1))); // pulse is one cycle
        tbl.push_back(vec(1, 1, 2'b01, 0, mk(0,0,0,3'd1,2'd1)));
        tbl.push_back(vec(1, 1, 2'b11, 0, mk(0,0,0,3'd2,2'd1)));
        tbl.push_back(vec(0, 0, 2'b00, 0, mk(0,0,0,3'd0,2'd0))); // reset mid-sequence
        tbl.push_back(vec(1, 1, 2'b00, 0, mk(0,0,1,3'd0,2'd1))); // 00 is not symbol 0
        tbl.push_back(vec(1, 0, 2'b00, 0, mk(0,0,0,3'd0,2'd1)));
        tbl.push_back(vec(1, 0, 2'b00, 1, mk(0,0,0,3'd0,2'd0))); // clear resets fail_cnt
        tbl.push_back(vec(1, 1, 2'b01, 0, mk(0,0,0,3'd1,2'd0)));
        tbl.push_back(vec(1, 1, 2'b11, 1, mk(0,0,0,3'd0,2'd0))); // clear in COLLECT
        tbl.push_back(vec(0, 1, 2'b01, 0, mk(0,0,0,3'd0,2'd0))); // reset beats sym

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst_n, tbl[i].v, tbl[i].s, tbl[i].c);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Three back-to-back failures into lockout.
        cyc(1, 1, 2'b11, 0); chk("lk_fail1", mk(0,0,1,3'd0,2'd1));
        cyc(1, 1, 2'b11, 0); chk("lk_fail2", mk(0,0,1,3'd0,2'd2));
        cyc(1, 1, 2'b11, 0); chk("lk_enter", mk(0,1,1,3'd0,2'd3));
        for (int i = 1; i < 16; i++) begin
            // Correct-key strobes and clear pulses must be ignored.
            cyc(1, 1, ks[i % 4], (i % 3) == 0);
            chk($sformatf("lk_hold%0d", i), mk(0,1,0,3'd0,2'd3));
        end
        cyc(1, 0, 2'b00, 0); chk("lk_exit", mk(0,0,0,3'd0,2'd0));
        cyc(1, 1, 2'b01, 0); chk("lk_key1", mk(0,0,0,3'd1,2'd0));
        cyc(1, 1, 2'b11, 0); chk("lk_key2", mk(0,0,0,3'd2,2'd0));
        cyc(1, 1, 2'b00, 0); chk("lk_key3", mk(0,0,0,3'd3,2'd0));
        cyc(1, 1, 2'b10, 0); chk("lk_open", mk(1,0,0,3'd0,2'd0));
        cyc(1, 0, 2'b00, 1); chk("lk_clear", mk(0,0,0,3'd0,2'd0));

        // Key change to all-zero symbols, consecutive strobes.
        cyc(0, 0, 2'b00, 0); chk("k0_reset", mk(0,0,0,3'd0,2'd0));
        key = 8'h00;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 2'b00, 0);
            chk($sformatf("k0_b2b%0d", i), (i == 3) ? mk(1,0,0,3'd0,2'd0)
                                                    : mk(0,0,0,3'(i + 1),2'd0));
        end
        cyc(1, 0, 2'b00, 1); chk("k0_clear", mk(0,0,0,3'd0,2'd0));

        // Same entry with idle gaps between strobes.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = (i == 3) ? mk(1,0,0,3'd0,2'd0) : mk(0,0,0,3'(i + 1),2'd0);
            cyc(1, 1, 2'b00, 0); chk($sformatf("k0_gap%0d", i), e);
            cyc(1, 0, 2'b00, 0); chk($sformatf("k0_gap%0d_idle1", i), e);
            cyc(1, 0, 2'b00, 0); chk($sformatf("k0_gap%0d_idle2", i), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eq2_seq_lock.md
Name: eq2_seq_lock

Overview:
- Sequential code-lock stage built around the 2-bit equality comparator.
- Accepts a strobed stream of 2-bit symbols and compares each one against the expected symbol of a programmed N-symbol key, using sum-of-products 2-bit equality logic.
- Tracks progress, failed attempts and a timed lockout, and drives unlock/status flags to downstream control logic.
- Sits between the switch/button sampling front end and the LED/status display.

Parameters:
- N_SYM, 4: key length in symbols; legal range 2..8.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout; legal range 1..3.
- LOCKOUT_CYC, 16: lockout duration in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- sym_valid  in  1  one-cycle strobe; sym is valid this cycle.
- sym  in  2  entered symbol.
- key  in  2*N_SYM  programmed key; symbol i is key[2i+1:2i], and symbol 0 is entered first.
- clear  in  1  abort the current attempt / relock.
- unlocked  out  1  high while in OPEN.
- locked_out  out  1  high while in LOCKOUT.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- pos  out  3  index of the next expected symbol.
- fail_cnt  out  2  current count of consecutive failed attempts.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; pos=0, fail_cnt=0, timer=0; unlocked=0, locked_out=0, fail_pulse=0. Reset overrides every other input, including mid-sequence and mid-lockout.
- All outputs are registered. The response to a sym_valid in cycle t is visible in cycle t+1.
- Symbol compare: match = (sym == key[2*pos+1:2*pos]), implemented as SOP equality.
- key is read combinationally at each compare. A key change takes effect on the next accepted symbol.
- States: IDLE, COLLECT, OPEN, LOCKOUT.
- IDLE or COLLECT, sym_valid=1, clear=0:
  - match and pos < N_SYM-1: pos <= pos+1; state <= COLLECT.
  - match and pos == N_SYM-1: state <= OPEN; pos <= 0; fail_cnt <= 0.
  - mismatch: pos <= 0; fail_pulse <= 1 for one cycle; fail_cnt <= fail_cnt+1.
    - If the new count equals MAX_FAIL: state <= LOCKOUT; timer <= LOCKOUT_CYC.
    - Otherwise: state <= IDLE.
  - A mismatching symbol is not re-evaluated as symbol 0 (no overlap restart).
- clear=1 in IDLE, COLLECT or OPEN: state <= IDLE; pos <= 0; fail_cnt <= 0. clear has priority over a simultaneous sym_valid; that symbol is dropped and no fail_pulse is generated.
- OPEN: unlocked=1. sym_valid is ignored. The block stays in OPEN until clear or reset.
- LOCKOUT:
  - locked_out=1. sym_valid and clear are ignored, with no fail_pulse and no pos change.
  - timer decrements every cycle.
  - When timer==1: state <= IDLE; fail_cnt <= 0; timer <= 0.
  - locked_out is therefore high for exactly LOCKOUT_CYC consecutive cycles.
- fail_pulse is 0 in every cycle other than the one following a mismatch. Back-to-back mismatches give back-to-back pulses.
- Widths: pos is 3 bits and never exceeds N_SYM-1. fail_cnt saturates by construction because it reaches MAX_FAIL only on entering LOCKOUT. timer is 8 bits.

Test Plan:
Common setup for all scenarios: N_SYM=4, MAX_FAIL=3, LOCKOUT_CYC=16, key=8'h8D (symbol sequence 01, 11, 00, 10).
1. Reset, then enter 01,11,00,10 on consecutive sym_valid cycles -> pos steps 1,2,3,0; unlocked=1 one cycle after the fourth strobe; fail_cnt=0; no fail_pulse.
2. Enter 01 then 10 -> pos=1 then 0; exactly one fail_pulse in the cycle after the second strobe; fail_cnt=1; unlocked stays 0.
3. Fail three times (symbol 11, then 11, then 11) -> fail_cnt goes 1,2,3; third failure gives locked_out=1 for exactly 16 cycles; correct-key strobes during lockout have no effect; afterwards state=IDLE with fail_cnt=0, and the correct key then unlocks.
4. In OPEN, pulse clear and strobe sym_valid in the same cycle -> unlocked=0 the next cycle; pos=0; fail_cnt=0; no fail_pulse.
5. Mid-sequence (pos=2), drive reset=0 for one edge -> all outputs 0 the next cycle; an entry of 00 is then treated as symbol 0 and fails (pulse, fail_cnt=1).
6. Change key to 8'h00 after reset, then enter 00 four times -> unlock; sym_valid pulses with gaps of idle cycles between them give identical results.
